usb_tx_timer_p: RTL
===================

USB_TX_TIMER_P -- requirements
Module: usb_tx_timer_p

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clock cycles per USB bit period (>=2).
REQ-002 SHALL have parameter BITS_PER_BYTE, default 8: data bits per byte (>=1).
REQ-003 SHALL have parameter CNT_W, default 8: width of the byte counter and of byte_total.
REQ-004 SHALL have port clk  in  1  system clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tim_clr  in  1  synchronous clear of all counters and state.
REQ-007 SHALL have port tim_en  in  1  count enable; low freezes all counters.
REQ-008 SHALL have port stuff_req  in  1  sampled at a bit boundary; requests that the next bit period be a stuff bit.
REQ-009 SHALL have port byte_total  in  CNT_W  number of bytes in the packet; sampled on the IDLE->RUN transition.
REQ-010 SHALL have port bit_strobe  out  1  one-cycle pulse at each bit-period end.
REQ-011 SHALL have port stuff_bit  out  1  high for the whole of a stuff-bit period.
REQ-012 SHALL have port load_byte  out  1  one-cycle pulse when BITS_PER_BYTE data bits complete.
REQ-013 SHALL have port byte_cnt  out  CNT_W  count of completed bytes.
REQ-014 SHALL have port eod  out  1  end of data, sticky until tim_clr or rst.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 SHALL transition IDLE->RUN on an edge with tim_en=1 and tim_clr=0, latch byte_total, and count that edge as the first clock of bit 0.
REQ-017 SHALL keep clk_cnt 0..CLKS_PER_BIT-1, incremented only on edges with tim_en=1 in IDLE->RUN or RUN; the wrap edge is the bit boundary.
REQ-018 SHALL raise bit_strobe for exactly the cycle after each bit boundary; the first strobe follows the CLKS_PER_BIT-th enabled edge; the period is CLKS_PER_BIT while tim_en stays high.
REQ-019 SHALL, at each bit boundary, load stuff_bit <= stuff_req; stuff periods do not advance bit_cnt.
REQ-020 SHALL, at a non-stuff boundary, increment bit_cnt; on the wrap of bit_cnt from BITS_PER_BYTE-1 to 0, pulse load_byte and increment byte_cnt in the same cycle.
REQ-021 SHALL, when byte_cnt reaches the latched total, set eod in the same cycle as the final load_byte and enter DONE, unless stuff_req=1 at that boundary.
REQ-022 SHALL, in that case, run the stuff period and then set eod and enter DONE at the stuff-period boundary, with no further load_byte.
REQ-023 SHALL, when the latched total is 0, enter DONE with eod=1 on the edge after IDLE->RUN, with no bit_strobe.
REQ-024 SHALL, in DONE, hold eod=1, freeze the counters, keep strobes at 0, and ignore tim_en and stuff_req.
REQ-025 SHALL, with tim_en=0 in RUN, freeze clk_cnt, bit_cnt, byte_cnt and stuff_bit; bit_strobe and load_byte remain 0 for those cycles.
REQ-026 SHALL give tim_clr priority over tim_en and stuff_req: on the next edge, go to IDLE and zero all counters and outputs.
REQ-027 SHALL never wrap byte_cnt, since counting stops at byte_total <= 2^CNT_W-1.

Reset
REQ-028 SHALL, on rst high, immediately force state IDLE, clk_cnt=bit_cnt=byte_cnt=0, bit_strobe=stuff_bit=load_byte=eod=0, including mid-operation.
REQ-029 SHALL, after rst release, resume only via the REQ-016 transition.

Structure
REQ-030 SHALL take the state enum and default parameter constants from shared package usb_tx_pkg.
REQ-031 SHALL instantiate sub-module usb_mod_counter (parametrised modulus, enable, sync clear, wrap pulse) for clk_cnt and bit_cnt.

Verification (CLKS_PER_BIT=8, BITS_PER_BYTE=8, CNT_W=8)
REQ-032 SHALL cover: rst pulse mid-RUN -> all outputs 0 asynchronously; idle until tim_en is reasserted.
REQ-033 SHALL cover: byte_total=2, tim_en held high -> bit_strobe after edges 8,16,...,128; load_byte with edges 64 and 128; byte_cnt=2 and eod=1 after edge 128, then constant.
REQ-034 SHALL cover: byte_total=1, stuff_req=1 at the 6th boundary -> stuff_bit high for edges 49-56; load_byte after edge 72; eod after edge 72.
REQ-035 SHALL cover: byte_total=1, stuff_req=1 at the 8th boundary -> load_byte after edge 64; eod deferred to after edge 72.
REQ-036 SHALL cover: tim_en low for 5 cycles during bit 3 -> all later strobes delayed by 5 cycles; no strobe while low.
REQ-037 SHALL cover: tim_clr with tim_en=1 at byte_cnt=1 -> IDLE next cycle with byte_cnt=0 and eod=0; byte_total=0 -> eod after the 2nd enabled edge, no bit_strobe.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and default sizing for the USB transmit timing blocks.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_CLKS_PER_BIT  = 8;
    localparam int unsigned DEF_BITS_PER_BYTE = 8;
    localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/usb_mod_counter.sv
// Modulo-MOD counter with enable and synchronous clear; wrap_c flags the enabled edge that returns to 0.
module usb_mod_counter #(
    parameter int unsigned MOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap_c
);

    localparam int unsigned W = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    assign wrap_c = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/usb_tx_timer_p.sv
// Bit/byte timing for a USB transmitter: bit strobes, stuff-bit periods, byte loads and end-of-data.
module usb_tx_timer_p
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int unsigned BITS_PER_BYTE = DEF_BITS_PER_BYTE,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tim_clr,
    input  logic             tim_en,
    input  logic             stuff_req,
    input  logic [CNT_W-1:0] byte_total,
    output logic             bit_strobe,
    output logic             stuff_bit,
    output logic             load_byte,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             eod
);

    state_t           state;
    logic [CNT_W-1:0] total;
    logic             eod_pend;

    logic             clk_en_c;
    logic             boundary_c;
    logic             bit_en_c;
    logic             byte_wrap_c;
    logic [CNT_W-1:0] byte_nxt_c;

    // A zero-length packet never runs the bit clock; it only waits one enabled edge in RUN.
    assign clk_en_c   = tim_en && !tim_clr &&
                        ((state == IDLE) || ((state == RUN) && (total != '0)));
    assign bit_en_c   = boundary_c && !stuff_bit;
    assign byte_nxt_c = byte_cnt + CNT_W'(1);

    usb_mod_counter #(.MOD(CLKS_PER_BIT)) u_clk_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (tim_clr),
        .en     (clk_en_c),
        .wrap_c (boundary_c)
    );

    usb_mod_counter #(.MOD(BITS_PER_BYTE)) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (tim_clr),
        .en     (bit_en_c),
        .wrap_c (byte_wrap_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            total      <= '0;
            eod_pend   <= 1'b0;
            bit_strobe <= 1'b0;
            stuff_bit  <= 1'b0;
            load_byte  <= 1'b0;
            byte_cnt   <= '0;
            eod        <= 1'b0;
        end else if (tim_clr) begin
            state      <= IDLE;
            total      <= '0;
            eod_pend   <= 1'b0;
            bit_strobe <= 1'b0;
            stuff_bit  <= 1'b0;
            load_byte  <= 1'b0;
            byte_cnt   <= '0;
            eod        <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            load_byte  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tim_en) begin
                        state <= RUN;
                        total <= byte_total;
                    end
                end
                RUN: begin
                    if (tim_en && (total == '0)) begin
                        state <= DONE;
                        eod   <= 1'b1;
                    end else if (boundary_c) begin
                        bit_strobe <= 1'b1;
                        // A stuff bit requested on the last byte defers eod to the end of that stuff period.
                        if (eod_pend) begin
                            state     <= DONE;
                            eod       <= 1'b1;
                            eod_pend  <= 1'b0;
                            stuff_bit <= 1'b0;
                        end else begin
                            stuff_bit <= stuff_req;
                            if (byte_wrap_c) begin
                                load_byte <= 1'b1;
                                byte_cnt  <= byte_nxt_c;
                                if (byte_nxt_c == total) begin
                                    if (stuff_req) begin
                                        eod_pend <= 1'b1;
                                    end else begin
                                        state <= DONE;
                                        eod   <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    eod <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
